// File: rtl/seq_pkg.sv
// Shared types and default pattern constants for the round-robin pattern sequencer.
// Pure declarations; no timing or backpressure of its own.
package seq_pkg;

  typedef logic [1:0] step_t;
  typedef logic [2:0] pat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam pat_t S0 = 3'b101;
  localparam pat_t S1 = 3'b110;
  localparam pat_t S2 = 3'b011;
  localparam pat_t S3 = 3'b001;

  function automatic pat_t default_pat(input step_t idx);
    case (idx)
      2'd0:    default_pat = S0;
      2'd1:    default_pat = S1;
      2'd2:    default_pat = S2;
      default: default_pat = S3;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from ptr, wrapping at NUM_REQ.
// Combinational, zero latency; no backpressure, caller decides when to take the grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin : search
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/seq_scheduler.sv
// Shares one 4-step pattern sequencer among NUM_REQ requesters; grant and first step appear at the sampling edge.
// One step per cycle while granted; a requester withdrawing req mid-burst aborts it without done.
module seq_scheduler
  import seq_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_addr,
  input  logic [2:0]                 cfg_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       seq_valid,
  output logic [2:0]                 seq_out,
  output logic [$clog2(NUM_REQ)-1:0] seq_owner,
  output logic [NUM_REQ-1:0]         done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = LEN_W + 1;
  localparam logic [1:0] GAP_INIT = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

  state_t           state;
  pat_t             pat_tbl [4];
  step_t            step;
  logic [CNT_W-1:0] rem;
  logic [1:0]       gap_cnt;
  logic [IDX_W-1:0] ptr;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [LEN_W-1:0]   len_raw;
  logic [CNT_W-1:0]   len_sel;
  logic [IDX_W-1:0]   ptr_next;
  logic               burst_end;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // A zero length field encodes the full 2^LEN_W steps.
  assign len_raw   = req_len[int'(arb_idx)*LEN_W +: LEN_W];
  assign len_sel   = (len_raw == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_raw};
  assign ptr_next  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
  assign burst_end = (rem == CNT_W'(1)) || !req[seq_owner];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) pat_tbl[i] <= default_pat(step_t'(i));
    end else if (cfg_we) begin
      pat_tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      step      <= '0;
      rem       <= '0;
      gap_cnt   <= '0;
      ptr       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      seq_valid <= 1'b0;
      seq_out   <= '0;
      seq_owner <= '0;
      done      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            state     <= RUN;
            grant     <= arb_onehot;
            busy      <= 1'b1;
            seq_valid <= 1'b1;
            seq_out   <= pat_tbl[0];
            seq_owner <= arb_idx;
            step      <= 2'd1;
            rem       <= len_sel;
            done      <= (len_sel == CNT_W'(1)) ? arb_onehot : '0;
            ptr       <= ptr_next;
          end
        end

        RUN: begin
          if (burst_end) begin
            grant     <= '0;
            seq_valid <= 1'b0;
            seq_out   <= '0;
            seq_owner <= '0;
            done      <= '0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_INIT;
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            // Reads the table before any same-edge write lands.
            seq_out <= pat_tbl[step];
            step    <= step + 1'b1;
            rem     <= rem - 1'b1;
            done    <= (rem == CNT_W'(2)) ? grant : '0;
          end
        end

        GAP: begin
          if (gap_cnt == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scheduler.sv
// Scoreboarded bench for seq_scheduler: directed scenarios plus randomized traffic against a cycle model.
module tb_seq_scheduler;

  localparam int N   = 4;
  localparam int LW  = 4;
  localparam int GAP = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [2:0]    cfg_data = '0;
  logic [N-1:0]  grant;
  logic          busy;
  logic          seq_valid;
  logic [2:0]    seq_out;
  logic [1:0]    seq_owner;
  logic [N-1:0]  done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seq_scheduler #(.NUM_REQ(N), .LEN_W(LW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_len(req_len),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .grant(grant), .busy(busy), .seq_valid(seq_valid), .seq_out(seq_out),
    .seq_owner(seq_owner), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       valid;
    bit       busy;
    logic [N-1:0] grant;
    logic [N-1:0] done;
    int       val;
    int       owner;
  } exp_t;

  typedef struct {
    int cyc;
    int owner;
    int val;
    bit done;
  } obs_t;

  exp_t sb_q[$];
  obs_t obs[$];

  // Reference model: burst bookkeeping in plain integers.
  int       m_left, m_owner, m_k, m_gap, m_pri, m_val;
  logic [2:0] m_tbl [4];

  function automatic void model_reset();
    m_left = 0; m_owner = 0; m_k = 0; m_gap = 0; m_pri = 0; m_val = 0;
    m_tbl[0] = 3'b101; m_tbl[1] = 3'b110; m_tbl[2] = 3'b011; m_tbl[3] = 3'b001;
  endfunction

  function automatic void model_step();
    exp_t e;
    bit   found;
    if (m_left > 0) begin
      if (m_left == 1 || !req[m_owner]) begin
        m_left = 0;
        m_gap  = GAP;
      end else begin
        m_left = m_left - 1;
        m_k    = m_k + 1;
        m_val  = int'(m_tbl[m_k % 4]);
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_pri + i) % N;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_k     = 0;
          m_left  = int'(req_len[c*LW +: LW]);
          if (m_left == 0) m_left = 1 << LW;
          m_val   = int'(m_tbl[0]);
          m_pri   = (c + 1) % N;
        end
      end
    end
    if (cfg_we) m_tbl[cfg_addr] = cfg_data;
    e.valid = (m_left > 0);
    e.busy  = (m_left > 0) || (m_gap > 0);
    e.grant = e.valid ? N'(1 << m_owner) : '0;
    e.done  = (m_left == 1) ? N'(1 << m_owner) : '0;
    e.val   = m_val;
    e.owner = m_owner;
    sb_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    req = '0;
    cfg_we = 1'b0;
    repeat (n) tick();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", int'({grant, done, busy, seq_valid, seq_out, seq_owner}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per active edge once stimulus has been issued.
  initial begin
    exp_t e;
    obs_t o;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (grant !== e.grant || done !== e.done || seq_valid !== e.valid || busy !== e.busy ||
            (e.valid && (int'(seq_out) != e.val || int'(seq_owner) != e.owner))) begin
          failures++;
          $display("FAIL sb cyc=%0d got v=%b g=%b d=%b b=%b out=%0d own=%0d exp v=%b g=%b d=%b b=%b out=%0d own=%0d",
                   cyc, seq_valid, grant, done, busy, seq_out, seq_owner,
                   e.valid, e.grant, e.done, e.busy, e.val, e.owner);
        end
        if (seq_valid) begin
          o.cyc = cyc; o.owner = int'(seq_owner); o.val = int'(seq_out); o.done = |done;
          obs.push_back(o);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pat[4];
    int exp6[6];
    int exp4[4];
    int exp3[3];
    int own8[8];
    int nd;
    pat  = '{5, 6, 3, 1};
    exp6 = '{5, 6, 3, 1, 5, 6};
    exp4 = '{5, 6, 7, 1};
    exp3 = '{5, 6, 3};
    own8 = '{1, 1, 3, 3, 1, 1, 3, 3};

    #3;
    chk("reset_outs", int'({grant, done, busy, seq_valid, seq_out, seq_owner}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single burst of 6.
    obs.delete();
    req = 4'b0001; req_len = 16'h0006;
    repeat (6) tick();
    idle_ticks(4);
    chk("single_len", obs.size(), 6);
    for (int k = 0; k < 6 && k < obs.size(); k++) chk("single_val", obs[k].val, exp6[k]);
    nd = 0;
    foreach (obs[k]) if (obs[k].done) nd++;
    chk("single_done_cnt", nd, 1);
    if (obs.size() == 6) chk("single_done_last", int'(obs[5].done), 1);

    // Contention between requesters 1 and 3.
    obs.delete();
    req = 4'b1010; req_len = 16'h2222;
    repeat (16) tick();
    idle_ticks(4);
    chk("cont_len", obs.size(), 8);
    for (int k = 0; k < 8 && k < obs.size(); k++) chk("cont_owner", obs[k].owner, own8[k]);
    if (obs.size() >= 3) chk("cont_spacing", obs[2].cyc - obs[1].cyc, GAP + 2);

    // Length zero means 16 steps.
    obs.delete();
    req = 4'b0001; req_len = 16'h0000;
    repeat (16) tick();
    idle_ticks(4);
    chk("len0_len", obs.size(), 16);
    nd = 0;
    foreach (obs[k]) begin
      if (obs[k].done) nd++;
      chk("len0_val", obs[k].val, pat[k % 4]);
    end
    chk("len0_done_cnt", nd, 1);

    // Table write lands for step 2, then reset restores defaults.
    obs.delete();
    req = 4'b0001; req_len = 16'h0004;
    tick();
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 3'b111;
    tick();
    cfg_we = 1'b0;
    repeat (2) tick();
    idle_ticks(4);
    chk("tblw_len", obs.size(), 4);
    for (int k = 0; k < 4 && k < obs.size(); k++) chk("tblw_val", obs[k].val, exp4[k]);
    do_async_reset();
    obs.delete();
    req = 4'b0001; req_len = 16'h0003;
    repeat (3) tick();
    idle_ticks(4);
    chk("tbl_reset_len", obs.size(), 3);
    for (int k = 0; k < 3 && k < obs.size(); k++) chk("tbl_reset_val", obs[k].val, exp3[k]);

    // Abort on the third step of eight; requester 1 arrives mid-burst.
    obs.delete();
    req = 4'b0001; req_len = 16'h0028;
    tick();
    req = 4'b0011;
    repeat (2) tick();
    req = 4'b0010;
    repeat (4) tick();
    idle_ticks(4);
    chk("abort_len", obs.size(), 5);
    nd = 0;
    for (int k = 0; k < 3 && k < obs.size(); k++) begin
      chk("abort_owner0", obs[k].owner, 0);
      if (obs[k].done) nd++;
    end
    chk("abort_no_done", nd, 0);
    if (obs.size() == 5) begin
      chk("abort_next_owner", obs[3].owner, 1);
      chk("abort_spacing", obs[3].cyc - obs[2].cyc, GAP + 2);
      chk("abort_next_done", int'(obs[4].done), 1);
    end

    // Reset mid-burst, then requester 0 beats requester 2.
    req = 4'b0001; req_len = 16'h0008;
    repeat (3) tick();
    do_async_reset();
    obs.delete();
    req = 4'b0101; req_len = 16'h0303;
    repeat (3) tick();
    idle_ticks(4);
    if (obs.size() > 0) chk("rst_first_owner", obs[0].owner, 0);
    else chk("rst_first_owner_seen", 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) < 3) do_async_reset();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (m_left == 1 && m_owner == i) begin
            if ($urandom_range(0, 99) < 80) req[i] = 1'b0;
          end else if ($urandom_range(0, 99) < 2) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < 20) begin
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 99) < 20) req_len = 16'($urandom);
      cfg_we   = ($urandom_range(0, 99) < 10);
      cfg_addr = 2'($urandom);
      cfg_data = 3'($urandom);
      tick();
    end
    idle_ticks(6);

    @(posedge clk);
    #2;
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_scheduler.md
# seq_scheduler

Round-robin scheduler that shares one 4-step, 3-bit pattern sequencer among `NUM_REQ` requesters. Each granted requester receives a burst of programmed pattern values, one per cycle, cycling through a runtime-writable 4-entry table. The block sits between the client blocks and the sequence output bus. It owns arbitration, burst length counting, the pattern table, and the completion handshake.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `LEN_W`, default 4: width of each per-requester burst length field.
- `GAP_CYCLES`, default 1: idle cycles inserted between bursts (0..3).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: level request; held high until the matching `done`.
- `req_len` in `NUM_REQ*LEN_W`: burst length of requester i in bits [i*LEN_W +: LEN_W]; value 0 means 2^LEN_W steps.
- `cfg_we` in 1: pattern table write strobe.
- `cfg_addr` in 2: table index to write.
- `cfg_data` in 3: table value to write.
- `grant` out `NUM_REQ`: one-hot; high for the whole burst.
- `busy` out 1: high whenever the state is not IDLE.
- `seq_valid` out 1: high while `seq_out` carries a step.
- `seq_out` out 3: current pattern value.
- `seq_owner` out `$clog2(NUM_REQ)`: index of the granted requester; valid when `seq_valid` is high.
- `done` out `NUM_REQ`: one-cycle pulse on the last step of a completed burst.

## Operation
- **States:**
  - IDLE: go to RUN if any `req` bit is set, otherwise stay.
  - RUN: stay until the last step or an abort.
  - On leaving RUN, go to GAP if `GAP_CYCLES` > 0, otherwise to IDLE.
  - GAP: count down `GAP_CYCLES`, then go to IDLE.
- **Arbitration:**
  - Round-robin, searching upward from (last winner + 1) mod `NUM_REQ`.
  - The pointer updates only when a grant is issued.
  - After reset, requester 0 has the highest priority.
- **Burst length:** latched from `req_len[winner]` at grant time. Later changes to `req_len` do not affect the running burst.
- **Step index:** 2-bit, starts at 0, increments every RUN cycle, and wraps 3 -> 0. `seq_out` = table[step].
- **Pattern table:**
  - Reset values: entry 0 = 3'b101, entry 1 = 3'b110, entry 2 = 3'b011, entry 3 = 3'b001.
  - `cfg_we` is accepted in every state.
- **Abort:** if `req[owner]` drops during RUN, the burst ends.
  - From the next edge, `grant` and `seq_valid` are 0.
  - No `done` pulse is issued.
  - The block enters GAP or IDLE as for a normal burst end.
- **Simultaneous events:**
  - A `req` bit rising during RUN or GAP waits for IDLE.
  - A `req` drop on the same cycle as the last step is a normal completion and `done` pulses.
- **Reset (asynchronous, any time, including mid-burst):** all outputs go to 0, the state goes to IDLE, the table returns to its defaults, and the round-robin pointer selects requester 0 first.

## Timing
- All outputs are registered.
- **Grant latency:** `req` sampled high in IDLE at edge E -> at E, `grant`, `busy`, `seq_valid`, `seq_owner` and `seq_out` = table[0] are all asserted.
- **Step rate:** one step per cycle, so an N-step burst occupies exactly N cycles of `seq_valid`.
- **`done[owner]`:** high in the same cycle as the final `seq_valid`.
- **Burst end:** on the next edge, `grant` = 0 and `seq_valid` = 0.
- **Back-to-back bursts:** the next grant comes no earlier than `GAP_CYCLES` + 1 cycles after the last valid. With `GAP_CYCLES` = 0 that is exactly 1 cycle, spent in IDLE.
- **Table write vs. read:** a write at edge E is visible to the step registered at E+1. A step registered at E reads the old value, even at the same address.

## Structure
- **Package `seq_pkg`:**
  - Default pattern constants `S0`..`S3` (101, 110, 011, 001).
  - 2-bit step type.
  - State enum {IDLE, RUN, GAP}.
- **Sub-module `rr_arbiter`:** parameterised by `NUM_REQ`.
  - Inputs: `req` vector, current pointer.
  - Outputs: one-hot winner, winner index, `any` flag.
  - Purely combinational.
- **Top level:** holds the FSM, length counter, step counter, table registers and output registers.

## Test plan
- **Single burst:** after reset, `req` = 4'b0001 with `req_len[0]` = 6. Expect `seq_out` = 101, 110, 011, 001, 101, 110 on 6 consecutive cycles, `done[0]` on the 6th, then `grant` = 0.
- **Contention:** `req` = 4'b1010 held, lengths 2 each. Expect the grant order 1, 3, 1, 3, with `GAP_CYCLES` + 1 idle cycles between bursts.
- **Length zero:** `req_len` = 0. Expect 16 valid steps with the pattern repeating 4 times, and a single `done`.
- **Table write mid-burst:** write entry 2 = 3'b111 during step 1. Expect step 2 = 111; after reset, expect entry 2 = 011 again.
- **Abort:** drop `req[0]` during step 3 of 8. Expect `seq_valid` = 0 on the next cycle, no `done`, and the next requester granted after the gap.
- **Asynchronous reset mid-burst:** assert `reset` low between edges. Expect all outputs 0 immediately; after release, requester 0 wins over a simultaneous `req[2]`.
